// File: rtl/param_stream_sink.sv
// rtl/param_stream_sink.sv - valid/ready parameter capture RAM with 2-cycle ROM read port; optional PARAM_SINK_OVERWRITE_EN
module param_stream_sink #(
   parameter int DATA_IN_PRECISION_0       = 16,
   parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
   parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
   parameter int DATA_IN_PARALLELISM_DIM_1 = 1,
   parameter int IN_DEPTH                  = DATA_IN_TENSOR_SIZE_DIM_0 / DATA_IN_PARALLELISM_DIM_0,
   parameter int ADDR_WIDTH                = $clog2(IN_DEPTH) + 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_IN_PRECISION_0-1:0]       data_in [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1],
   input  logic                                 data_in_valid,
   output logic                                 data_in_ready,
   input  logic                                 clear,
   output logic                                 done,
   output logic [ADDR_WIDTH-1:0]                beat_count,
   input  logic [ADDR_WIDTH-1:0]                address0,
   input  logic                                 ce0,
   output logic [DATA_IN_PRECISION_0*DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1-1:0] q0,
   output logic                                 overflow
);

   localparam int P     = DATA_IN_PRECISION_0;
   localparam int LANES = DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1;
   localparam int W     = P * LANES;
   localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

   typedef enum logic [0:0] {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_beat_count;
   logic                  r_done;
   logic [W-1:0]          r_ram [IN_DEPTH];
   logic [W-1:0]          r_stage0;
   logic [W-1:0]          r_stage1;
   logic [W-1:0]          w_word;
   logic [W-1:0]          w_rd_word;
   logic [IDX_W-1:0]      w_rd_idx;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_last;

   // Pack lanes: lane j lands at bits [P*j +: P]
   always_comb begin
      w_word = '0;
      for (int j = 0; j < LANES; j++) begin
         w_word[P*j +: P] = data_in[j];
      end
   end

   // Ready per state; clear always blocks the same-cycle beat
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_FILL: w_ready = !clear;
`ifdef PARAM_SINK_OVERWRITE_EN
         S_FULL: w_ready = !clear;
`else
         S_FULL: w_ready = 1'b0;
`endif
         default: w_ready = 1'b0;
      endcase
   end

   assign w_accept = data_in_valid && w_ready;
   assign w_last   = (r_wr_ptr == IDX_W'(IN_DEPTH - 1));

   // Next state: the last word of a fill moves to FULL, clear returns to FILL
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = S_FILL;
      end else if (r_state == S_FILL && w_accept && w_last) begin
         w_state_nxt = S_FULL;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_FILL;
      else      r_state <= w_state_nxt;
   end

   // Write pointer, beat count and done bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_beat_count <= '0;
         r_done       <= 1'b0;
      end else if (clear) begin
         r_wr_ptr     <= '0;
         r_beat_count <= '0;
         r_done       <= 1'b0;
      end else if (w_accept) begin
         r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
         if (r_beat_count != ADDR_WIDTH'(IN_DEPTH)) r_beat_count <= r_beat_count + 1'b1;
         if (w_last) r_done <= 1'b1;
      end
   end

`ifdef PARAM_SINK_OVERWRITE_EN
   logic r_overflow;

   // Sticky flag for any beat that overwrites a completed capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                r_overflow <= 1'b0;
      else if (clear)                          r_overflow <= 1'b0;
      else if (w_accept && r_state == S_FULL)  r_overflow <= 1'b1;
   end

   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   // Capture RAM write; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (w_accept) r_ram[r_wr_ptr] <= w_word;
   end

   assign w_rd_idx  = address0[IDX_W-1:0];
   assign w_rd_word = (address0 < ADDR_WIDTH'(IN_DEPTH)) ? r_ram[w_rd_idx] : '0;

   // Two-stage read pipeline; old RAM word is seen on a same-address write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stage0 <= '0;
         r_stage1 <= '0;
      end else if (ce0) begin
         r_stage0 <= w_rd_word;
         r_stage1 <= r_stage0;
      end
   end

   assign data_in_ready = w_ready;
   assign done          = r_done;
   assign beat_count    = r_beat_count;
   assign q0            = r_stage1;

endmodule

// File: tb/tb_param_stream_sink.sv
// tb/tb_param_stream_sink.sv - randomized self-checking bench for param_stream_sink
module tb_param_stream_sink;

`ifdef PARAM_SINK_OVERWRITE_EN
   localparam bit OVW = 1'b1;
`else
   localparam bit OVW = 1'b0;
`endif
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] din [1];
   logic        valid = 1'b0;
   logic        ready;
   logic        clr = 1'b0;
   logic        done;
   logic [5:0]  bcnt;
   logic [5:0]  addr = '0;
   logic        ce = 1'b0;
   logic [15:0] q0;
   logic        ovf;

   logic [15:0] din4 [4];
   logic        valid4 = 1'b0;
   logic        ready4;
   logic        clr4 = 1'b0;
   logic        done4;
   logic [3:0]  bcnt4;
   logic [3:0]  addr4 = '0;
   logic        ce4 = 1'b0;
   logic [63:0] q4;
   logic        ovf4;

   int total = 0;
   int bad   = 0;

   // Reference model: captured words, fill count, flags, 2-deep read latency line
   logic [15:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   int          m_cnt, m_wr;
   bit          m_done, m_ovf;
   logic [15:0] m_s0, m_s1;
   bit          m_k0, m_k1;

   always #5 clk = ~clk;

   param_stream_sink dut (
      .clk(clk), .rst(rst), .data_in(din), .data_in_valid(valid), .data_in_ready(ready),
      .clear(clr), .done(done), .beat_count(bcnt), .address0(addr), .ce0(ce), .q0(q0),
      .overflow(ovf)
   );

   param_stream_sink #(.DATA_IN_PARALLELISM_DIM_0(4)) dut4 (
      .clk(clk), .rst(rst), .data_in(din4), .data_in_valid(valid4), .data_in_ready(ready4),
      .clear(clr4), .done(done4), .beat_count(bcnt4), .address0(addr4), .ce0(ce4), .q0(q4),
      .overflow(ovf4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_wr = 0; m_done = 0; m_ovf = 0;
      m_s0 = '0; m_s1 = '0; m_k0 = 1; m_k1 = 1;
   endtask

   // One clock: entered at posedge+1 with inputs set; checks ready mid-cycle, state after the edge
   task automatic tick(output bit acc);
      bit exp_rdy;
      #4;
      exp_rdy = !clr && (!m_done || OVW);
      chk("ready", ready, exp_rdy);
      acc = valid && exp_rdy;
      if (ce) begin
         m_s1 = m_s0; m_k1 = m_k0;
         if (addr < DEPTH) begin m_s0 = m_mem[addr]; m_k0 = m_known[addr]; end
         else              begin m_s0 = '0;          m_k0 = 1;             end
      end
      if (clr) begin
         m_cnt = 0; m_wr = 0; m_done = 0; m_ovf = 0;
      end else if (acc) begin
         m_mem[m_wr] = din[0]; m_known[m_wr] = 1;
         if (m_done) m_ovf = 1;
         m_wr = (m_wr + 1) % DEPTH;
         if (m_cnt < DEPTH) m_cnt++;
         if (m_cnt == DEPTH) m_done = 1;
      end
      @(posedge clk); #1;
      chk("done", done, m_done);
      chk("beat_count", bcnt, m_cnt);
      chk("overflow", ovf, m_ovf);
      if (m_k1) chk("q0", q0, m_s1);
   endtask

   initial begin
      bit          acc;
      int          nacc;
      bit          cleared;
      logic [15:0] held;
      logic [63:0] w4 [8];

      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
      din[0] = '0;
      for (int j = 0; j < 4; j++) din4[j] = '0;
      model_reset();

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_done", done, 0);
      chk("rst_count", bcnt, 0);
      chk("rst_q0", q0, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b1;

      // Fill with value i, valid held high
      for (int i = 0; i < DEPTH; i++) begin
         din[0] = 16'(i); valid = 1'b1;
         tick(acc);
      end
      chk("fill_done", done, 1);
      chk("fill_count", bcnt, 32);
`ifndef PARAM_SINK_OVERWRITE_EN
      din[0] = 16'h0099;
      tick(acc);
      chk("full_stall_ready", ready, 0);
`endif
      valid = 1'b0;

      // Readback of fixed addresses, 2-cycle latency
      ce = 1'b1;
      addr = 6'd0;  tick(acc);
      addr = 6'd5;  tick(acc);
      chk("rd_addr0", q0, 16'h0000);
      addr = 6'd31; tick(acc);
      chk("rd_addr5", q0, 16'h0005);
      addr = 6'd40; tick(acc);
      chk("rd_addr31", q0, 16'h001F);
      addr = 6'd3;  tick(acc);
      chk("rd_addr40", q0, 16'h0000);
      tick(acc);

      // ce0 low holds the pipeline
      held = q0;
      ce = 1'b0;
      for (int k = 0; k < 3; k++) begin
         addr = 6'($urandom_range(0, 40));
         tick(acc);
      end
      chk("ce0_hold", q0, held);

      // Random gaps, clear alongside beat 10, refill until done
      nacc = 0; cleared = 0;
      for (int c = 0; c < 600 && !(cleared && m_done); c++) begin
         valid  = ($urandom_range(0, 3) != 0);
         din[0] = 16'($urandom);
         ce     = 1'($urandom_range(0, 1));
         addr   = 6'($urandom_range(0, 40));
         if (!cleared && nacc == 10) begin
            clr = 1'b1; valid = 1'b1; cleared = 1;
         end
         tick(acc);
         if (clr) chk("clear_count", bcnt, 0);
         clr = 1'b0;
         if (!cleared && acc) nacc++;
      end
      chk("refill_done", done, 1);
      valid = 1'b0;
      ce = 1'b1;
      addr = 6'd0; tick(acc); tick(acc); tick(acc);

      // Asynchronous reset mid-fill
      clr = 1'b1; tick(acc); clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         din[0] = 16'($urandom); valid = 1'b1;
         tick(acc);
      end
      valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_done", done, 0);
      chk("arst_count", bcnt, 0);
      chk("arst_q0", q0, 0);
      model_reset();
      @(posedge clk); #1 rst = 1'b1;
      din[0] = 16'hABCD; valid = 1'b1; addr = 6'd1;
      tick(acc);
      valid = 1'b0; addr = 6'd0;
      tick(acc); tick(acc); tick(acc);
      chk("arst_refill_addr0", q0, 16'hABCD);

`ifdef PARAM_SINK_OVERWRITE_EN
      // Overwrite: 34 beats, then clear drops overflow
      clr = 1'b1; tick(acc); clr = 1'b0;
      for (int i = 0; i < 34; i++) begin
         din[0] = 16'(16'h1000 + i); valid = 1'b1;
         tick(acc);
      end
      valid = 1'b0;
      chk("ovw_overflow", ovf, 1);
      chk("ovw_count", bcnt, 32);
      addr = 6'd1; tick(acc); tick(acc); tick(acc);
      chk("ovw_addr1", q0, 16'h1021);
      clr = 1'b1; tick(acc); clr = 1'b0;
      chk("ovw_clear", ovf, 0);
`else
      chk("no_ovw_overflow", ovf, 0);
`endif

      // Four-lane instance: lanes {4,3,2,1} then random beats
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 4; j++) din4[j] = (b == 0) ? 16'(j + 1) : 16'($urandom);
         w4[b] = {din4[3], din4[2], din4[1], din4[0]};
         valid4 = 1'b1;
         #4;
         chk("par4_ready", ready4, 1);
         @(posedge clk); #1;
      end
      valid4 = 1'b0;
      chk("par4_done", done4, 1);
      chk("par4_count", bcnt4, 8);
      ce4 = 1'b1;
      for (int a = 0; a < 8; a += 7) begin
         addr4 = 4'(a);
         @(posedge clk); @(posedge clk); #1;
         chk("par4_word", q4, w4[a]);
      end
      chk("par4_first_word", w4[0], 64'h0004_0003_0002_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_stream_sink.md
Name: param_stream_sink

Overview:
- Receiving end of the parameter-source stream protocol: consumes a valid/ready tensor stream of PRECISION-wide lanes and packs each beat into one RAM word.
- Stores exactly IN_DEPTH beats, then signals done.
- Exposes a ROM-style read port (address0/ce0/q0, 2-cycle latency) for checking or reusing the captured parameters.
- Used as the capture endpoint in cocotb benches and as the write side of on-chip parameter buffers.

Parameters:
- DATA_IN_PRECISION_0, 16, bit width of one lane
- DATA_IN_TENSOR_SIZE_DIM_0, 32, elements per tensor row
- DATA_IN_PARALLELISM_DIM_0, 1, lanes per beat in dim 0
- DATA_IN_PARALLELISM_DIM_1, 1, lanes per beat in dim 1
- IN_DEPTH, DATA_IN_TENSOR_SIZE_DIM_0/DATA_IN_PARALLELISM_DIM_0, beats per tensor (RAM words)
- ADDR_WIDTH, $clog2(IN_DEPTH)+1, read address and count width

Ports:
- clk, input, 1, the single clock
- rst, input, 1, asynchronous active-low reset
- data_in, input, [PRECISION-1:0] x (PAR0*PAR1), unpacked lane array
- data_in_valid, input, 1, beat valid
- data_in_ready, output, 1, sink can accept a beat
- clear, input, 1, synchronous pulse: discard capture and restart at word 0
- done, output, 1, IN_DEPTH beats captured
- beat_count, output, ADDR_WIDTH, beats captured so far (0..IN_DEPTH)
- address0, input, ADDR_WIDTH, read address
- ce0, input, 1, read-pipeline clock enable
- q0, output, PRECISION*PAR0*PAR1, read data
- overflow, output, 1, sticky flag; tied to 0 unless PARAM_SINK_OVERWRITE_EN is defined

Behaviour:
- Word packing: W = PRECISION*PAR0*PAR1. Lane j occupies bits [PRECISION*j +: PRECISION] of the word.
- Reset (rst=0, asynchronous):
  - state=FILL, wr_ptr=0, beat_count=0, done=0, overflow=0.
  - Both q0 pipeline stages cleared, so q0=0.
  - RAM contents are not reset.
- States:
  - FILL: data_in_ready = !clear.
  - FULL: data_in_ready = 0.
- Accept: a beat is accepted when data_in_valid && data_in_ready at a rising edge. On acceptance:
  - ram[wr_ptr] <= packed word; beat_count increments.
  - If wr_ptr == IN_DEPTH-1: wr_ptr <= 0, state <= FULL, done <= 1 in the same edge.
  - Otherwise wr_ptr <= wr_ptr+1.
- Stalls: valid without ready holds state. Producer data must stay stable until accepted; the sink keeps no skid buffer.
- clear (synchronous, from any state):
  - wr_ptr=0, beat_count=0, done=0, overflow=0, state=FILL.
  - clear has priority over a same-cycle beat; that beat is not accepted because ready is low.
  - RAM contents are kept.
- Readback:
  - When ce0=1: stage0 <= ram[address0], stage1 <= stage0, q0 = stage1. Latency is 2 cycles.
  - When ce0=0: both stages hold.
  - address0 >= IN_DEPTH reads 0.
- Read/write collision at the same address in the same cycle is read-first: the old word is returned.
- Reads are legal in any state, including during FILL.
- done and beat_count are registered and update on the accepting edge.

Optional Feature:
- Macro PARAM_SINK_OVERWRITE_EN.
- Defined:
  - FULL keeps data_in_ready = !clear.
  - An accepted beat in FULL overwrites ram[wr_ptr] circularly, wrapping at IN_DEPTH-1 back to 0.
  - overflow is set and stays set until clear or reset.
  - done stays 1; beat_count saturates at IN_DEPTH.
- Undefined: FULL stalls the producer; overflow is constant 0.

Test Plan:
- Reset, then stream 32 beats of value i (PAR=1, P=16) with valid held high -> ready stays high for 32 cycles; done rises on the edge accepting beat 31; ready=0 afterwards; beat_count=32.
- After fill, read addr 0,5,31 with ce0=1 -> q0 = 0x0000, 0x0005, 0x001F, each 2 cycles after its address. Read addr 40 -> q0=0.
- PAR0=4 config, beat lanes {4,3,2,1} -> word = 0x0004_0003_0002_0001; IN_DEPTH=8; done after 8 beats.
- Random valid gaps plus clear pulsed alongside beat 10 -> beat 10 not accepted; beat_count=0; next beat written at addr 0; done after 32 further beats.
- rst low mid-fill (after 12 beats) -> done=0, beat_count=0, q0=0 immediately; the next fill starts at addr 0. Toggle ce0=0 during reads -> q0 holds.
- With PARAM_SINK_OVERWRITE_EN: 34 beats -> beats 32 and 33 overwrite addr 0 and 1; overflow=1; clear -> overflow=0.
